dpmem_fifo_ctrl: RTL

- Initiator side of the 8x4 dual-port memory (`memSintetizado`).
- Presents a push/pop FIFO interface to the rest of the design.
- Drives port A of the memory as the write port and port B as the read port.
- Owns the pointers, occupancy count, full/empty/almost-full flags and sticky error flags.
- The memory is the responder: this block replaces the tester as the agent driving its address, rw and data pins.

---
 rtl/dpmem_fifo_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dpmem_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dpmem_fifo_ctrl
//   Initiator side of the 8x4 dual-port memory (memSintetizado). Presents a
//   push/pop FIFO to the rest of the design, drives memory port A as the
//   write port and port B as the read port, and owns the read/write
//   pointers, occupancy count, status flags and sticky error flags.
//
// Ports
//   clk, reset          rising-edge clock (shared with memory), sync active-high reset
//   push, push_data     enqueue request and data
//   pop                 dequeue request
//   pop_data, pop_valid dequeued data, valid during the one-cycle pop_valid pulse
//   full, empty         count == DEPTH / count == 0
//   almost_full         count >= ALMOST_FULL
//   count               occupancy, 0..DEPTH
//   overflow_err        sticky, push while full
//   underflow_err       sticky, pop while empty
//   AddrA, rwA, DataInA memory port A (write side)
//   AddrB, rwB          memory port B (read side, rwB held at 0)
//   DataOutB            memory port B read data, one cycle after AddrB
// ---------------------------------------------------------------------------
module dpmem_fifo_ctrl #(
  parameter int AW          = 3,
  parameter int DW          = 4,
  parameter int ALMOST_FULL = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic [AW-1:0] AddrA,
  output logic          rwA,
  output logic [DW-1:0] DataInA,
  output logic [AW-1:0] AddrB,
  output logic          rwB,
  input  logic [DW-1:0] DataOutB
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(ALMOST_FULL);

  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   countReg;
  logic          popValidReg;
  logic [DW-1:0] heldData;
  logic          overflowReg;
  logic          underflowReg;
  logic          pushAcc;
  logic          popAcc;

  // Flags decode from the registered count only, so accept decisions never
  // depend on same-cycle requests.
  assign full        = (countReg == DEPTH_CNT);
  assign empty       = (countReg == {(AW+1){1'b0}});
  assign almost_full = (countReg >= AFULL_CNT);
  assign count       = countReg;

  // Accept decode: a push while full or a pop while empty is dropped.
  always_comb begin
    pushAcc = 1'b0;
    popAcc  = 1'b0;
    if (push && !full) begin
      pushAcc = 1'b1;
    end else begin
      pushAcc = 1'b0;
    end
    if (pop && !empty) begin
      popAcc = 1'b1;
    end else begin
      popAcc = 1'b0;
    end
  end

  // Memory port drive. The pointers never alias while both ports are active,
  // because a simultaneous push/pop implies 0 < count < DEPTH.
  assign AddrA   = wrPtr;
  assign DataInA = push_data;
  assign rwA     = pushAcc;
  assign AddrB   = rdPtr;
  assign rwB     = 1'b0;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= {AW{1'b0}};
      rdPtr    <= {AW{1'b0}};
      countReg <= {(AW+1){1'b0}};
    end else begin
      if (pushAcc) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (popAcc) begin
        rdPtr <= rdPtr + AW'(1);
      end
      countReg <= countReg + (AW+1)'(pushAcc) - (AW+1)'(popAcc);
    end
  end

  // Read-return tracking: the memory answers one cycle after AddrB, so the
  // valid pulse trails the accepted pop by one cycle. A reset drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      popValidReg <= 1'b0;
      heldData    <= {DW{1'b0}};
    end else begin
      popValidReg <= popAcc;
      if (popValidReg) begin
        heldData <= DataOutB;
      end
    end
  end

  // During the valid pulse the memory output is forwarded directly; the
  // captured copy keeps pop_data stable until the next pulse.
  assign pop_valid = popValidReg;
  assign pop_data  = popValidReg ? DataOutB : heldData;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      if (push && full) begin
        overflowReg <= 1'b1;
      end
      if (pop && empty) begin
        underflowReg <= 1'b1;
      end
    end
  end

  assign overflow_err  = overflowReg;
  assign underflow_err = underflowReg;

endmodule
